// File: rtl/mux_pipe_pkg.sv
// Shared types and helpers for the mux_pipe_nb registered selector.
// Used by both the explicit-select build and the MUX_RR_EN round-robin build.
package mux_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  // Channel-id width; a 2-way selector still needs one bit.
  function automatic int selWidth(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_pipe_nb_rr_arb.sv
// rr_arb: N-way rotating-priority arbiter with its own priority pointer.
// Instantiated by mux_pipe_nb only when MUX_RR_EN is defined.
module rr_arb #(
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     i_valid,
  input  logic             i_accept,
  output logic [SEL_W-1:0] o_grant,
  output logic             o_grantValid
);

  logic [SEL_W-1:0] r_ptr;
  int               w_idx;

  // Scan from the far end back toward ptr so the closest requester wins.
  always_comb begin
    o_grant      = '0;
    o_grantValid = 1'b0;
    w_idx        = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = (int'(r_ptr) + i) % N;
      if (i_valid[w_idx]) begin
        o_grant      = SEL_W'(w_idx);
        o_grantValid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= SEL_W'((int'(o_grant) + 1) % N);
    end
  end

endmodule

// File: rtl/mux_pipe_nb.sv
// mux_pipe_nb: N-way registered selector with a 2-entry skid buffer on the output.
// Define MUX_RR_EN to replace the sel input with round-robin arbitration.
module mux_pipe_nb
  import mux_pipe_pkg::*;
#(
  parameter  int WIDTH = 5,
  parameter  int N     = 2,
  localparam int SEL_W = selWidth(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  state_t           r_state;
  state_t           w_stateNext;
  logic             r_en;
  logic [WIDTH-1:0] r_mainData;
  logic [SEL_W-1:0] r_mainCh;
  logic [WIDTH-1:0] r_skidData;
  logic [SEL_W-1:0] r_skidCh;

  logic [SEL_W-1:0] w_grant;
  logic             w_grantValid;
  logic [WIDTH-1:0] w_inWord;
  logic             w_skidValid;
  logic             w_accept;
  logic             w_drain;
  logic             w_loadMainIn;
  logic             w_loadMainSkid;
  logic             w_loadSkid;

`ifdef MUX_RR_EN
  logic w_unusedSel;
  assign w_unusedSel = ^sel;

  rr_arb #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rrArb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (in_valid),
    .i_accept     (w_accept),
    .o_grant      (w_grant),
    .o_grantValid (w_grantValid)
  );
`else
  assign w_grant      = sel;
  assign w_grantValid = (int'(sel) < N);
`endif

  assign w_skidValid = (r_state == ST_FULL);
  assign out_valid   = (r_state != ST_EMPTY);
  assign out_data    = r_mainData;
  assign out_ch      = r_mainCh;
  assign w_drain     = out_valid & out_ready;
  assign w_accept    = |(in_valid & in_ready);

  // Ready never looks at out_ready, so a stall does not ripple back combinationally.
  always_comb begin
    in_ready = '0;
    w_inWord = '0;
    for (int k = 0; k < N; k++) begin
      if (w_grant == SEL_W'(k)) begin
        in_ready[k] = r_en & w_grantValid & ~w_skidValid;
        w_inWord    = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_en    <= 1'b1;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_stateNext  = ST_ONE;
          w_loadMainIn = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          w_loadMainIn = 1'b1;
        end else if (w_accept) begin
          w_stateNext = ST_FULL;
          w_loadSkid  = 1'b1;
        end else if (w_drain) begin
          w_stateNext = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_drain) begin
          w_stateNext    = ST_ONE;
          w_loadMainSkid = 1'b1;
        end
      end
      default: w_stateNext = ST_EMPTY;
    endcase
  end

  // Main register keeps its last word when the buffer empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mainData <= '0;
      r_mainCh   <= '0;
      r_skidData <= '0;
      r_skidCh   <= '0;
    end else begin
      if (w_loadMainIn) begin
        r_mainData <= w_inWord;
        r_mainCh   <= w_grant;
      end else if (w_loadMainSkid) begin
        r_mainData <= r_skidData;
        r_mainCh   <= r_skidCh;
      end
      if (w_loadSkid) begin
        r_skidData <= w_inWord;
        r_skidCh   <= w_grant;
      end
    end
  end

endmodule
